uart_bus_ctrl: RTL

Bus-side control and configuration block for the UART. It decodes a simple single-cycle register bus and generates the oversampling clock enable from a programmable divisor. It drives the framing configuration (parity, stop bits) into the RX/TX controllers and pops/pushes the RX/TX queues. It also collects parity/stop-bit error pulses into sticky status flags and produces a level interrupt.

---
 rtl/uart_bus_ctrl_if.sv | 22 ++
 rtl/uart_bus_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_ctrl_if.sv
// ============================================================================
//  Module      : uart_bus_ctrl_if
//  Description : Single-cycle register bus between a host and the UART
//                control block. The host drives address, strobes and write
//                data. The control block returns read data one cycle after
//                the read strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_bus_ctrl_if;
  logic [3:0]  bus_addr;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (output bus_addr, bus_we, bus_re, bus_wdata, input bus_rdata);
  modport slave  (input bus_addr, bus_we, bus_re, bus_wdata, output bus_rdata);
endinterface

`default_nettype wire

// File: rtl/uart_bus_ctrl.sv
// ============================================================================
//  Module      : uart_bus_ctrl
//  Description : Bus-side control block for the UART. It provides the
//                following functions:
//                  - register decode for DATA, STATUS, CTRL and BAUD
//                  - RX queue pops and TX queue pushes
//                  - sticky error flags and a level interrupt
//                  - framing configuration that is applied only while both
//                    controllers are idle
//                  - oversampling clock-enable generation
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_bus_ctrl #(
  parameter int                   DATA_WIDTH = 8,
  parameter int                   DIV_WIDTH  = 16,
  parameter logic [DIV_WIDTH-1:0] DIV_RESET  = 16'd54
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  uart_bus_ctrl_if.slave             bus,
  input  wire logic [DATA_WIDTH-1:0] rx_queue_rdata,
  input  wire logic                  rx_queue_empty,
  input  wire logic                  rx_queue_full,
  output logic                       rx_queue_re,
  input  wire logic                  tx_queue_full,
  input  wire logic                  tx_queue_empty,
  output logic                       tx_queue_we,
  output logic [DATA_WIDTH-1:0]      tx_queue_wdata,
  input  wire logic                  rx_busy,
  input  wire logic                  tx_busy,
  input  wire logic                  parity_error_if,
  input  wire logic                  stop_bit_error_if,
  output logic                       clk_en,
  output logic                       parity_en,
  output logic                       parity_odd,
  output logic                       double_stop_bit,
  output logic                       irq
);

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_BAUD   = 2'd3;

  // Decoded access. A simultaneous write and read is treated as a write only.
  logic [1:0] sel;
  logic       wr;
  logic       rd;
  assign sel = bus.bus_addr[3:2];
  assign wr  = bus.bus_we;
  assign rd  = bus.bus_re & ~bus.bus_we;

  // Address bits [1:0] and the upper write-data bits carry no meaning here.
  wire unused_bus_bits = &{1'b0, bus.bus_addr[1:0], bus.bus_wdata};

  logic                 perr;
  logic                 serr;
  logic                 tx_ovf;
  logic                 cfg_pend;
  logic [2:0]           cfg_shadow;
  logic                 ie_rx;
  logic                 ie_tx;
  logic                 ie_err;
  logic [DIV_WIDTH-1:0] divisor;
  logic [DIV_WIDTH-1:0] baud_cnt;

  logic data_wr;
  logic data_rd;
  logic status_wr;
  logic ctrl_wr;
  logic baud_wr;
  assign data_wr   = wr & (sel == REG_DATA);
  assign data_rd   = rd & (sel == REG_DATA);
  assign status_wr = wr & (sel == REG_STATUS);
  assign ctrl_wr   = wr & (sel == REG_CTRL);
  assign baud_wr   = wr & (sel == REG_BAUD);

  // Queue strobes are same-cycle pulses; they are suppressed during reset.
  assign rx_queue_re    = data_rd & ~rx_queue_empty & ~reset;
  assign tx_queue_we    = data_wr & ~tx_queue_full & ~reset;
  assign tx_queue_wdata = tx_queue_we ? bus.bus_wdata[DATA_WIDTH-1:0] : '0;

  // A divisor of 0 or 1 reloads to 0 so that clk_en fires every cycle.
  logic [DIV_WIDTH-1:0] new_div;
  logic [DIV_WIDTH-1:0] reload_cur;
  logic [DIV_WIDTH-1:0] reload_new;
  assign new_div    = bus.bus_wdata[DIV_WIDTH-1:0];
  assign reload_cur = (divisor[DIV_WIDTH-1:1] == '0) ? '0 : divisor - 1'b1;
  assign reload_new = (new_div[DIV_WIDTH-1:1] == '0) ? '0 : new_div - 1'b1;

  logic [31:0] status_word;
  assign status_word = {24'd0, cfg_pend, tx_ovf, serr, perr,
                        tx_queue_full, tx_queue_empty, rx_queue_full, rx_queue_empty};

  // Read-data mux; an idle bus or a colliding write yields zero.
  logic [31:0] rdata_next;
  always_comb begin
    rdata_next = '0;
    if (rd) begin
      unique case (sel)
        REG_DATA:   rdata_next = rx_queue_empty ? 32'd0
                               : {{(32-DATA_WIDTH){1'b0}}, rx_queue_rdata};
        REG_STATUS: rdata_next = status_word;
        REG_CTRL:   rdata_next = {21'd0, ie_err, ie_tx, ie_rx, 5'd0, cfg_shadow};
        REG_BAUD:   rdata_next = {{(32-DIV_WIDTH){1'b0}}, divisor};
        default:    rdata_next = '0;
      endcase
    end
  end

  // Register read data so it is valid the cycle after the read strobe.
  always_ff @(posedge clk) begin
    if (reset) bus.bus_rdata <= '0;
    else       bus.bus_rdata <= rdata_next;
  end

  // Sticky error flags; a set in the same cycle as a clear keeps the flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      perr   <= 1'b0;
      serr   <= 1'b0;
      tx_ovf <= 1'b0;
    end else begin
      perr   <= parity_error_if | (perr & ~(status_wr & bus.bus_wdata[4]));
      serr   <= stop_bit_error_if | (serr & ~(status_wr & bus.bus_wdata[5]));
      tx_ovf <= (data_wr & tx_queue_full) | (tx_ovf & ~(status_wr & bus.bus_wdata[6]));
    end
  end

  // Control shadow and interrupt enables; framing reaches the active outputs
  // only when both controllers are idle. A new write keeps the update pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_shadow      <= '0;
      cfg_pend        <= 1'b0;
      ie_rx           <= 1'b0;
      ie_tx           <= 1'b0;
      ie_err          <= 1'b0;
      parity_en       <= 1'b0;
      parity_odd      <= 1'b0;
      double_stop_bit <= 1'b0;
    end else begin
      if (cfg_pend && !rx_busy && !tx_busy) begin
        parity_en       <= cfg_shadow[0];
        parity_odd      <= cfg_shadow[1];
        double_stop_bit <= cfg_shadow[2];
        cfg_pend        <= 1'b0;
      end
      if (ctrl_wr) begin
        cfg_shadow <= bus.bus_wdata[2:0];
        cfg_pend   <= 1'b1;
        ie_rx      <= bus.bus_wdata[8];
        ie_tx      <= bus.bus_wdata[9];
        ie_err     <= bus.bus_wdata[10];
      end
    end
  end

  // Level interrupt, registered from the current enables and sources.
  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= (ie_rx & ~rx_queue_empty) | (ie_tx & tx_queue_empty)
                    | (ie_err & (perr | serr | tx_ovf));
  end

  // Baud down-counter; a BAUD write restarts the count from the new divisor.
  always_ff @(posedge clk) begin
    if (reset) begin
      divisor  <= DIV_RESET;
      baud_cnt <= (DIV_RESET[DIV_WIDTH-1:1] == '0) ? '0 : DIV_RESET - 1'b1;
      clk_en   <= 1'b0;
    end else if (baud_wr) begin
      divisor  <= new_div;
      baud_cnt <= reload_new;
      clk_en   <= 1'b0;
    end else begin
      clk_en   <= (baud_cnt == '0);
      baud_cnt <= (baud_cnt == '0) ? reload_cur : baud_cnt - 1'b1;
    end
  end

endmodule

`default_nettype wire
